lsu_mem_responder: RTL and testbench

- Memory-stage load/store responder. It takes MEM-stage access requests (address, store data, size, direction) and drives a ready/valid data-memory port.
- Returns the aligned, sign/zero-extended ReadData to the MEM/WB pipeline register.
- Asserts StallM while an access is outstanding, so the pipeline holds the instruction in MEM until the access completes.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_load_align.sv | 22 ++
 rtl/lsu_mem_responder.sv | 123 ++++++++++++
 tb/tb_lsu_mem_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM encoding and size helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Only funct3[1:0] carries the size; the unsigned bit and the 111 code fall out as D.
    function automatic logic [7:0] size_mask(input logic [2:0] f3);
        return f3[1:0] == 2'd0 ? MASK_B : f3[1:0] == 2'd1 ? MASK_H : f3[1:0] == 2'd2 ? MASK_W : MASK_D;
    endfunction

    function automatic logic is_aligned(input logic [2:0] f3, input logic [2:0] off);
        return (off & {f3[1] & f3[0], f3[1], f3[1] | f3[0]}) == 3'b000;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts a read doubleword down to the accessed lane and sign/zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    output logic [63:0] data
);

    logic [63:0] sh;
    logic        sgn;

    always_comb begin
        sh   = rdata >> {off, 3'b000};
        sgn  = funct3 inside {F3_B, F3_H, F3_W};
        data = funct3[1:0] == 2'd0 ? {{56{sgn & sh[7]}}, sh[7:0]} :
               funct3[1:0] == 2'd1 ? {{48{sgn & sh[15]}}, sh[15:0]} :
               funct3[1:0] == 2'd2 ? {{32{sgn & sh[31]}}, sh[31:0]} : sh;
    end

endmodule

// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder: MEM-stage load/store responder driving a ready/valid data-memory port.
// Define LSU_PERF_CNT_EN to add the LoadCnt/StoreCnt/StallCnt performance counters.
module lsu_mem_responder
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
`ifdef LSU_PERF_CNT_EN
    output logic [63:0] LoadCnt,
    output logic [63:0] StoreCnt,
    output logic [63:0] StallCnt,
`endif
    input  logic [63:0] ALUResultM,
    input  logic [63:0] WriteDataM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    output logic [63:0] ReadData,
    output logic        StallM,
    output logic        MisalignedM,
    output logic        BusErrM,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_addr,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rdata
);

    localparam logic [WAIT_W-1:0] TMO = WAIT_W'(MAX_WAIT - 1);

    state_t            state, state_n;
    logic [WAIT_W-1:0] cnt;
    logic [2:0]        off, f3;
    logic              access, aligned, start, busy, hs, rsp, tmo;
    logic [63:0]       load_data;

    assign access  = MemReadM | MemWriteM;
    assign aligned = is_aligned(Funct3M, ALUResultM[2:0]);
    assign start   = state == IDLE && access && aligned;
    assign busy    = state == REQ || state == WAIT;
    assign hs      = state == REQ && mem_req_ready;
    assign rsp     = state == WAIT && mem_rsp_valid;
    // A handshake or response landing on the last allowed cycle still completes.
    assign tmo     = busy && cnt >= TMO && !hs && !rsp;

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .off    (off),
        .funct3 (f3),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? REQ : IDLE;
            REQ:     state_n = hs ? (mem_we ? DONE : WAIT) : tmo ? DONE : REQ;
            WAIT:    state_n = rsp || tmo ? DONE : WAIT;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        StallM        = start || busy;
        mem_req_valid = state == REQ;
        MisalignedM   = state == IDLE && access && !aligned;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            off       <= '0;
            f3        <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            ReadData  <= '0;
            BusErrM   <= 1'b0;
        end else begin
            BusErrM <= tmo;
            cnt     <= start ? '0 : busy ? cnt + 1'b1 : cnt;
            if (start) begin
                off       <= ALUResultM[2:0];
                f3        <= Funct3M;
                mem_addr  <= {ALUResultM[63:3], 3'b000};
                mem_we    <= MemWriteM;
                mem_wdata <= MemWriteM ? WriteDataM << {ALUResultM[2:0], 3'b000} : '0;
                mem_wstrb <= MemWriteM ? size_mask(Funct3M) << ALUResultM[2:0] : '0;
            end
            if (rsp)
                ReadData <= load_data;
            else if (tmo || MisalignedM)
                ReadData <= '0;
        end
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            LoadCnt  <= '0;
            StoreCnt <= '0;
            StallCnt <= '0;
        end else begin
            LoadCnt  <= LoadCnt + 64'(rsp);
            StoreCnt <= StoreCnt + 64'(hs && mem_we);
            StallCnt <= StallCnt + 64'(StallM);
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_responder.sv
// tb_lsu_mem_responder: randomized scoreboard bench with a reactive memory agent.
module tb_lsu_mem_responder;

    localparam int MW = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic [63:0] ALUResultM = '0, WriteDataM = '0, mem_rdata = '0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0, mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
    logic [2:0]  Funct3M = '0;
    logic [63:0] ReadData, mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        StallM, MisalignedM, BusErrM, mem_req_valid, mem_we;

    always #5 clk = ~clk;

    lsu_mem_responder #(.MAX_WAIT(MW), .WAIT_W(8)) dut (
        .clk(clk), .rst(rst),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ReadData(ReadData), .StallM(StallM), .MisalignedM(MisalignedM),
        .BusErrM(BusErrM), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    // kind: 0 completed, 1 timed out, 2 misaligned
    typedef struct { int kind; logic [63:0] data; int stalls; } rsp_t;
    typedef struct { logic [63:0] addr; logic we; logic [63:0] wdata; logic [7:0] wstrb; } req_t;

    rsp_t        rq[$];
    req_t        qq[$];
    int          checks = 0, failures = 0;
    int          rdy_delay = 0, rsp_delay = 0;
    bit          no_rsp = 0, force_rsp = 0;
    logic [63:0] mem_word = '0, last_rd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : f3[1:0] == 2'd2 ? 4 : 8;
    endfunction

    function automatic logic [63:0] load_model(input logic [63:0] w, input int off, input logic [2:0] f3);
        int n;
        logic [63:0] v, m;
        n = nbytes(f3);
        m = n == 8 ? '1 : (64'd1 << (8 * n)) - 64'd1;
        v = (w >> (8 * off)) & m;
        if (f3 inside {3'b000, 3'b001, 3'b010} && v[8 * n - 1]) v = v | ~m;
        return v;
    endfunction

    task automatic access(input logic rd, input logic wr, input logic [63:0] a, input logic [2:0] f3,
                          input logic [63:0] wd, input logic [63:0] rw, input int dr, input int ds, input bit nr);
        int off = int'(a[2:0]);
        int n = nbytes(f3);
        int k = 0;
        rsp_t e;
        req_t r;
        if (off % n != 0) begin
            e.kind = 2; e.data = '0; e.stalls = 0;
        end else begin
            r.addr = a & ~64'h7; r.we = wr; r.wdata = wd << (8 * off);
            r.wstrb = 8'(((1 << n) - 1) << off);
            qq.push_back(r);
            if (wr) begin
                e.kind = 0; e.data = last_rd; e.stalls = dr + 2;
            end else if (!nr && dr + ds + 2 <= MW) begin
                e.kind = 0; e.data = load_model(rw, off, f3); e.stalls = dr + ds + 3;
            end else begin
                e.kind = 1; e.data = '0; e.stalls = 1 + MW;
            end
        end
        last_rd = e.data;
        rq.push_back(e);
        rdy_delay = dr; rsp_delay = ds; no_rsp = nr; mem_word = rw;
        @(posedge clk); #1;
        MemReadM = rd; MemWriteM = wr; ALUResultM = a; Funct3M = f3; WriteDataM = wd;
        #1;
        while (StallM && k < 100) begin
            @(posedge clk); #2;
            k++;
        end
        if (k >= 100) begin
            checks++; failures++;
            $display("FAIL stall_bound: StallM still high after %0d cycles, required to drop", k);
        end
        @(posedge clk); #1;
        MemReadM = 0; MemWriteM = 0;
    endtask

    // Memory agent: acts 2 time units after each edge on what the DUT showed in the previous cycle.
    initial begin
        bit hs, hw, rv, pend;
        int rc, dc;
        pend = 0; rc = 0; dc = 0;
        forever begin
            @(negedge clk);
            hs = mem_req_valid && mem_req_ready; hw = mem_we; rv = mem_rsp_valid;
            @(posedge clk); #2;
            if (rv || !StallM || rst) pend = 0;
            if (hs && !hw) begin pend = 1; rc = rsp_delay; end
            mem_rdata = mem_word;
            mem_rsp_valid = force_rsp;
            if (pend && !no_rsp) begin
                if (rc == 0) mem_rsp_valid = 1; else rc--;
            end
            if (!mem_req_valid) dc = rdy_delay;
            mem_req_ready = 0;
            if (mem_req_valid && !hs) begin
                if (dc == 0) mem_req_ready = 1; else dc--;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT hands something off.
    initial begin
        int st_cnt = 0;
        bit prev = 0, zchk = 0;
        rsp_t e;
        req_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 0; st_cnt = 0; zchk = 0;
            end else begin
                if (zchk) begin chk("mis_readdata", ReadData, 64'd0); zchk = 0; end
                if (mem_req_valid && mem_req_ready) begin
                    if (qq.size() == 0) chk("unexpected_req", mem_addr, 64'hx);
                    else begin
                        r = qq.pop_front();
                        chk("req_addr", mem_addr, r.addr);
                        chk("req_we", mem_we, r.we);
                        if (r.we) begin
                            chk("req_wdata", mem_wdata, r.wdata);
                            chk("req_wstrb", mem_wstrb, r.wstrb);
                        end
                    end
                end
                if (MisalignedM) begin
                    if (rq.size() == 0) chk("unexpected_mis", 1, 0);
                    else begin
                        e = rq.pop_front();
                        chk("mis_kind", e.kind, 2);
                        chk("mis_stall", StallM, 0);
                        chk("mis_reqvalid", mem_req_valid, 0);
                        zchk = 1;
                    end
                end
                if (prev && !StallM) begin
                    if (rq.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        e = rq.pop_front();
                        chk("done_kind", e.kind == 2, 0);
                        chk("readdata", ReadData, e.data);
                        chk("buserr", BusErrM, e.kind == 1);
                        chk("stall_cycles", st_cnt, e.stalls);
                    end
                    st_cnt = 0;
                end
                if (StallM) st_cnt++;
                prev = StallM;
            end
        end
    end

    initial begin
        logic rd, wr;
        logic [2:0] f3;
        int sel;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readdata", ReadData, 0);
        chk("rst_stall", StallM, 0);
        chk("rst_reqvalid", mem_req_valid, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_flags", {MisalignedM, BusErrM}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        rst = 0;
        access(1, 0, 64'h1003, 3'b000, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 0);
        access(1, 0, 64'h1004, 3'b110, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 0);
        access(0, 1, 64'h2006, 3'b001, 64'hABCD, 64'h0, 0, 0, 0);
        access(1, 0, 64'h3002, 3'b010, 64'h0, 64'h0, 0, 0, 0);
        access(1, 0, 64'h4000, 3'b011, 64'h0, 64'h1234_5678_9ABC_DEF0, 0, 0, 1);
        access(1, 1, 64'h5004, 3'b010, 64'h1122_3344_5566_7788, 64'h0, 1, 0, 0);
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 2);
            rd = sel != 1; wr = sel != 0;
            f3 = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            access(rd, wr, {$urandom, $urandom}, f3, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 1), $urandom_range(0, 1), 0);
        end
        // Reset while a load waits, then a stray response must be ignored.
        qq.push_back('{addr: 64'h6000, we: 1'b0, wdata: 64'h0, wstrb: 8'h0});
        rdy_delay = 0; no_rsp = 1; mem_word = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        MemReadM = 1; ALUResultM = 64'h6000; Funct3M = 3'b011;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk); #1;
        rst = 0; MemReadM = 0; force_rsp = 1;
        @(posedge clk); #1;
        force_rsp = 0;
        @(negedge clk);
        chk("rstwait_readdata", ReadData, 0);
        chk("rstwait_stall", StallM, 0);
        chk("rstwait_reqvalid", mem_req_valid, 0);
        chk("rstwait_buserr", BusErrM, 0);
        repeat (2) @(negedge clk);
        chk("queues_empty", rq.size() + qq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
